distance_bcd_latch: RTL and testbench

Frame-synchronous distance front end for the VGA distance display. Accepts raw binary distance samples, clamps them to the displayable range, converts them to three BCD digits with an iterative double-dabble converter, and commits the result only at the start of vertical sync so digits never change mid-frame. Sits between the distance source and the VGA digit renderer, replacing its per-pixel divide/modulo logic with registered BCD digits.

---
 rtl/dist_disp_pkg.sv | 17 +
 rtl/bin2bcd_dd.sv | 49 ++++
 rtl/distance_bcd_latch.sv | 146 ++++++++++++++
 tb/tb_distance_bcd_latch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dist_disp_pkg.sv
// rtl/dist_disp_pkg.sv - shared constants and FSM state type for the distance display front end
// Optional feature macro: DIST_SMOOTH_AVG_EN (adds the AVG state for 4-sample smoothing)
package dist_disp_pkg;

  localparam int unsigned DIGITS   = 3;
  localparam int unsigned BCD_W    = 4 * DIGITS;
  localparam int unsigned CLAMP_W  = 10;
  localparam int unsigned MAX_DISP = 999;
  localparam int unsigned CNT_W    = 4;

`ifdef DIST_SMOOTH_AVG_EN
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_AVG} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_CONV} state_e;
`endif

endpackage

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - iterative double-dabble converter, one shift/add-3 step per cycle
module bin2bcd_dd
  import dist_disp_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [CLAMP_W-1:0] bin_i,
  input  logic               step_i,
  output logic [BCD_W-1:0]   bcd_o,
  output logic               done_o
);

  logic [CLAMP_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q;

  // Add-3 correction on every digit, then shift the next binary bit into the BCD field
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_d = {adj[BCD_W-2:0], bin_q[CLAMP_W-1]};
    bin_d = {bin_q[CLAMP_W-2:0], 1'b0};
  end

  // bcd_o is the post-step value, so it holds the final digits during the last step
  assign bcd_o  = bcd_d;
  assign done_o = (cnt_q == CNT_W'(CLAMP_W - 1));

  // Load a new operand or advance one iteration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/distance_bcd_latch.sv
// rtl/distance_bcd_latch.sv - clamp, BCD-convert and frame-commit distance samples for the VGA display
// Optional feature macro: DIST_SMOOTH_AVG_EN (converts the mean of the last 4 clamped samples)
module distance_bcd_latch #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned MAX_DISP = 999
) (
  input  logic                           iVGA_CLK,
  input  logic                           iRST_n,
  input  logic [IN_W-1:0]                iDIST,
  input  logic                           iDIST_VALID,
  output logic                           oDIST_READY,
  input  logic                           iVS,
  output logic [dist_disp_pkg::BCD_W-1:0] oBCD,
  output logic                           oOVER,
  output logic                           oUPD
);
  import dist_disp_pkg::*;

  localparam logic [IN_W-1:0] MAX_IN = IN_W'(MAX_DISP);

  state_e             state_q, state_d;
  logic               conv_over_q, conv_over_d;
  logic [BCD_W-1:0]   pend_bcd_q, bcd_q, cvt_bcd;
  logic               pend_over_q, pend_valid_q, over_q, upd_q, vs_d_q;
  logic               in_over, load, step, cvt_done, conv_done, commit;
  logic [CLAMP_W-1:0] in_clamp, load_bin;

  assign in_over  = (iDIST > MAX_IN);
  assign in_clamp = in_over ? CLAMP_W'(MAX_DISP) : iDIST[CLAMP_W-1:0];

`ifdef DIST_SMOOTH_AVG_EN
  logic [3:0][CLAMP_W-1:0] hist_q;
  logic [3:0]              hist_over_q;
  logic [CLAMP_W+1:0]      hist_sum;

  assign hist_sum = (CLAMP_W+2)'(hist_q[0]) + (CLAMP_W+2)'(hist_q[1])
                  + (CLAMP_W+2)'(hist_q[2]) + (CLAMP_W+2)'(hist_q[3]);

  // Shift each accepted clamped sample and its over flag into the 4-deep history
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hist_q      <= '0;
      hist_over_q <= '0;
    end else if (state_q == S_IDLE && iDIST_VALID) begin
      hist_q      <= {hist_q[2:0], in_clamp};
      hist_over_q <= {hist_over_q[2:0], in_over};
    end
  end
`endif

  // Next state, converter control and the over flag travelling with the conversion
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    step        = 1'b0;
    conv_done   = 1'b0;
    load_bin    = in_clamp;
    conv_over_d = conv_over_q;
    case (state_q)
      S_IDLE: begin
        if (iDIST_VALID) begin
`ifdef DIST_SMOOTH_AVG_EN
          state_d = S_AVG;
`else
          load        = 1'b1;
          conv_over_d = in_over;
          state_d     = S_CONV;
`endif
        end
      end
`ifdef DIST_SMOOTH_AVG_EN
      S_AVG: begin
        load        = 1'b1;
        load_bin    = hist_sum[CLAMP_W+1:2];
        conv_over_d = |hist_over_q;
        state_d     = S_CONV;
      end
`endif
      S_CONV: begin
        step = 1'b1;
        if (cvt_done) begin
          conv_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and conversion over-flag registers
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      conv_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_over_q <= conv_over_d;
    end
  end

  bin2bcd_dd u_bin2bcd (
    .clk_i  (iVGA_CLK),
    .rst_ni (iRST_n),
    .load_i (load),
    .bin_i  (load_bin),
    .step_i (step),
    .bcd_o  (cvt_bcd),
    .done_o (cvt_done)
  );

  // Commit on the registered falling edge of vsync, only when a fresh result is waiting
  assign commit = vs_d_q & ~iVS & pend_valid_q;

  // Pending result holding and frame-synchronous commit; commit reads the pre-edge pending value
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_d_q       <= 1'b1;
      upd_q        <= 1'b0;
      bcd_q        <= '0;
      over_q       <= 1'b0;
      pend_bcd_q   <= '0;
      pend_over_q  <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      vs_d_q <= iVS;
      upd_q  <= commit;
      if (commit) begin
        bcd_q  <= pend_bcd_q;
        over_q <= pend_over_q;
      end
      if (conv_done) begin
        pend_bcd_q   <= cvt_bcd;
        pend_over_q  <= conv_over_q;
        pend_valid_q <= 1'b1;
      end else if (commit) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign oDIST_READY = (state_q == S_IDLE);
  assign oBCD        = bcd_q;
  assign oOVER       = over_q;
  assign oUPD        = upd_q;

endmodule

// File: tb/tb_distance_bcd_latch.sv
// tb/tb_distance_bcd_latch.sv - randomized self-checking bench for distance_bcd_latch
module tb_distance_bcd_latch;

  logic        iVGA_CLK    = 1'b0;
  logic        iRST_n      = 1'b0;
  logic [31:0] iDIST       = '0;
  logic        iDIST_VALID = 1'b0;
  logic        iVS         = 1'b1;
  logic        oDIST_READY;
  logic [11:0] oBCD;
  logic        oOVER;
  logic        oUPD;

`ifdef DIST_SMOOTH_AVG_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 10;
`endif

  distance_bcd_latch #(.IN_W(32), .MAX_DISP(999)) dut (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .iDIST       (iDIST),
    .iDIST_VALID (iDIST_VALID),
    .oDIST_READY (oDIST_READY),
    .iVS         (iVS),
    .oBCD        (oBCD),
    .oOVER       (oOVER),
    .oUPD        (oUPD)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: absolute edge bookkeeping and decimal arithmetic
  int cyc = 0;
  int last_acc, fin_edge, conv_val, pend_val, com_val, upd_cnt;
  bit conv_over, pend_over, pend_v, com_over, prev_vs, exp_upd;
  int hist[$];
  bit hov[$];

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic m_reset();
    pend_v = 0; pend_val = 0; pend_over = 0;
    com_val = 0; com_over = 0; prev_vs = 1; exp_upd = 0;
    last_acc = -1000; fin_edge = -1;
    hist = '{0, 0, 0, 0};
    hov  = '{0, 0, 0, 0};
  endtask

  task automatic m_accept(input logic [31:0] d);
    int c;
    bit o;
    int s;
    bit any;
    o = (d > 32'd999);
    c = o ? 999 : int'(d);
    hist.push_back(c); hov.push_back(o);
    void'(hist.pop_front()); void'(hov.pop_front());
    s = 0; any = 0;
    foreach (hist[i]) begin s += hist[i]; any |= hov[i]; end
`ifdef DIST_SMOOTH_AVG_EN
    conv_val = s / 4; conv_over = any;
`else
    conv_val = c; conv_over = o;
`endif
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit vs);
    bit rdy, fall;
    iDIST_VALID = v; iDIST = d; iVS = vs;
    rdy = (cyc > last_acc + LAT);
    @(posedge iVGA_CLK);
    fall    = prev_vs && !vs;
    exp_upd = fall && pend_v;
    if (exp_upd) begin com_val = pend_val; com_over = pend_over; end
    if (cyc == fin_edge) begin pend_val = conv_val; pend_over = conv_over; pend_v = 1; end
    else if (exp_upd) pend_v = 0;
    if (rdy && v) begin m_accept(d); last_acc = cyc; fin_edge = cyc + LAT; end
    prev_vs = vs;
    cyc++;
    #1;
    if (oUPD === 1'b1) upd_cnt++;
    chk("bcd",   32'(oBCD),        32'(to_bcd(com_val)));
    chk("over",  32'(oOVER),       32'(com_over));
    chk("upd",   32'(oUPD),        32'(exp_upd));
    chk("ready", 32'(oDIST_READY), 32'(cyc > last_acc + LAT));
  endtask

  task automatic frame(input int n);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (n - 2) step(0, 0, 1);
  endtask

  task automatic send(input logic [31:0] d);
    int guard = 0;
    while (!oDIST_READY && guard < 30) begin step(0, 0, 1); guard++; end
    chk("send_ready", 32'(oDIST_READY), 32'd1);
    step(1, d, 1);
    repeat (LAT) step(0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge iVGA_CLK);
    iRST_n = 1'b0; iDIST_VALID = 1'b0; iVS = 1'b1;
    #1;
    chk("rst_bcd",   32'(oBCD),        32'h0);
    chk("rst_over",  32'(oOVER),       32'd0);
    chk("rst_upd",   32'(oUPD),        32'd0);
    chk("rst_ready", 32'(oDIST_READY), 32'd1);
    repeat (2) @(posedge iVGA_CLK);
    #1 iRST_n = 1'b1;
    m_reset();
  endtask

  initial begin
    int low, u0, vs_cnt, vs_per;
    bit v, vs;
    logic [31:0] d;
    upd_cnt = 0;
    m_reset();
    do_reset();

    repeat (3) frame(16);
    chk("idle_bcd", 32'(oBCD), 32'h0);
    chk("idle_upd_cnt", 32'(upd_cnt), 32'd0);

`ifdef DIST_SMOOTH_AVG_EN
    send(100); frame(16); chk("avg_025", 32'(oBCD), 32'h025);
    send(200); frame(16); chk("avg_075", 32'(oBCD), 32'h075);
    send(300); frame(16); chk("avg_150", 32'(oBCD), 32'h150);
    send(400); frame(16); chk("avg_250", 32'(oBCD), 32'h250);
`else
    send(437); frame(16);
    chk("bcd_437", 32'(oBCD), 32'h437); chk("over_437", 32'(oOVER), 32'd0);
    send(999); frame(16);
    chk("bcd_999", 32'(oBCD), 32'h999); chk("over_999", 32'(oOVER), 32'd0);
    send(1000); frame(16);
    chk("bcd_1000", 32'(oBCD), 32'h999); chk("over_1000", 32'(oOVER), 32'd1);
    send(32'hFFFF_FFFF); frame(16);
    chk("bcd_max", 32'(oBCD), 32'h999); chk("over_max", 32'(oOVER), 32'd1);
    send(12); send(85); frame(16);
    chk("latest_wins", 32'(oBCD), 32'h085);
    for (int i = 0; i < 25; i++) step(1, 32'(500 + i), 1);
    repeat (LAT) step(0, 0, 1);
    frame(16);
    chk("held_valid", 32'(oBCD), 32'h522);
    send(250);
    step(1, 300, 1);
    repeat (LAT - 1) step(0, 0, 1);
    step(0, 0, 0);
    chk("same_edge_old", 32'(oBCD), 32'h250);
    chk("same_edge_upd", 32'(oUPD), 32'd1);
    step(0, 0, 1);
    frame(16);
    chk("same_edge_new", 32'(oBCD), 32'h300);
`endif

    // busy duration and single update pulse
    while (!oDIST_READY) step(0, 0, 1);
    step(1, 437, 1);
    low = 0;
    while (!oDIST_READY && low < 40) begin low++; step(0, 0, 1); end
    chk("busy_len", 32'(low), 32'(LAT));
    u0 = upd_cnt; frame(16);
    chk("upd_once", 32'(upd_cnt - u0), 32'd1);
    u0 = upd_cnt; frame(16);
    chk("upd_none", 32'(upd_cnt - u0), 32'd0);

    // reset in the middle of a conversion
    step(1, 777, 1);
    repeat (4) step(0, 0, 1);
    do_reset();
    u0 = upd_cnt; frame(16);
    chk("rst_no_commit", 32'(upd_cnt - u0), 32'd0);
    chk("rst_bcd_hold", 32'(oBCD), 32'h0);

    // randomized traffic with varying frame lengths
    vs_cnt = 0; vs_per = 20;
    for (int i = 0; i < 1500; i++) begin
      vs = (vs_cnt >= 2);
      vs_cnt++;
      if (vs_cnt >= vs_per) begin vs_cnt = 0; vs_per = $urandom_range(6, 40); end
      v = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: d = $urandom_range(0, 999);
        1: d = 999;
        2: d = 1000;
        3: d = $urandom;
        default: d = $urandom_range(0, 99);
      endcase
      step(v, d, vs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
